mips_decode_stage: RTL and testbench
====================================

# mips_decode_stage

Registered decode stage for the multi-cycle MIPS CPU. It sits between fetch and execute, latches one 32-bit instruction per valid/ready handshake, and presents its decoded fields plus a one-hot operation class. It generates the pipeline stall for memory operations waiting on `waitrequest` and for HI/LO hazards behind a multi-cycle multiply/divide. Multiply and divide latencies are parameters.

## Interface
Parameters:
- `MULT_CYCLES`, 4: execute cycles occupied by mult/multu; must be ≥1.
- `DIV_CYCLES`, 32: execute cycles occupied by div/divu; must be ≥1.
- `CNT_W`, 6: busy-counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `instr_valid` in 1: fetch offers `instr`.
- `instr` in 32: instruction word.
- `instr_ready` out 1: stage accepts `instr` this cycle.
- `waitrequest` in 1: data memory busy.
- `d_ready` in 1: execute accepts the held instruction.
- `d_valid` out 1: held instruction valid.
- `stall` out 1: held instruction may not transfer this cycle.
- `rs`, `rt`, `rd`, `shamt` out 5 each: fields [25:21], [20:16], [15:11], [10:6].
- `immediate` out 16: [15:0].
- `address` out 26: [25:0].
- `opcode`, `funct` out 6 each: [31:26], [5:0].
- `op_class` out 7: one-hot {HILO_MOVE, MULDIV, STORE, LOAD, JUMP, BRANCH, ALU}, bit 0 = ALU.
- `illegal` out 1: held word is not a supported instruction.
- `trap` out 1: sticky illegal-instruction trap (see Configuration).

## Operation
- Supported set: addiu, addu, and, andi, beq, bgez, bgezal, bgtz, blez, bltz, bltzal, bne, div, divu, j, jal, jalr, jr, lb, lbu, lh, lhu, lui, lw, lwl, lwr, mfhi, mflo, mthi, mtlo, mult, multu, or, ori, sb, sh, sw, sll, sllv, slt, slti, sltiu, sltu, sra, srav, srl, srlv, subu, xor, xori. Encodings are standard MIPS32. REGIMM branches are selected by rt. bgtz and blez require rt=0.
- Class map:
  - LOAD: lb, lbu, lh, lhu, lw, lwl, lwr.
  - STORE: sb, sh, sw.
  - ALU: all arithmetic, logic, shift and slt ops, plus lui. lui is not a memory op.
  - BRANCH: conditional branches.
  - JUMP: j, jal, jr, jalr.
  - MULDIV: mult, multu, div, divu.
  - HILO_MOVE: mfhi, mflo, mthi, mtlo.
- Unsupported word: `illegal`=1, `op_class`=0.
- Accept: `instr_valid & instr_ready` latches `instr` and sets `d_valid`.
- `instr_ready` = !reset & !trap & (!d_valid | (d_ready & !stall)). Accept and transfer can occur in the same cycle.
- Transfer: `d_valid & d_ready & !stall`. `d_valid` clears unless a new word is accepted in the same cycle.
- `stall` = d_valid & ((LOAD|STORE) & waitrequest | (MULDIV|HILO_MOVE) & busy).
- Busy counter `cnt`, where busy = (cnt ≠ 0):
  - On transfer of mult/multu: load MULT_CYCLES.
  - On transfer of div/divu: load DIV_CYCLES.
  - Otherwise decrement when nonzero. A load takes priority over a decrement.
- Held fields are stable while `d_valid` is high and no transfer occurs.

## Timing
- Reset values:
  - d_valid=0, all field outputs=0, op_class=0, illegal=0, trap=0, cnt=0.
  - stall=0, instr_ready=0 while reset is high.
- Latency: accept at edge N gives `d_valid`=1 and valid fields after edge N. One decode per cycle at full throughput.
- Decode outputs are registered. `stall` and `instr_ready` are combinational from registered state plus `waitrequest`/`d_ready`.
- Mult transferred at edge N: cnt=MULT_CYCLES after N. A following mflo is stalled for MULT_CYCLES cycles and transfers no earlier than edge N+MULT_CYCLES+1.
- `waitrequest` dropping while `d_ready`=1: transfer in that same cycle.
- Reset mid-busy or mid-stall clears `cnt` and discards the held instruction.
- `d_ready`=0 with `stall`=0: instruction held, no accept, `cnt` still decrements.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN` defined:
  - When an illegal word is held, `trap` sets at the next edge and stays set until reset.
  - While `trap`=1: `instr_ready`=0 and `d_valid` forced 0.
  - The illegal word never transfers.
- Not defined:
  - `trap` is tied 0.
  - Illegal words transfer normally with `op_class`=0, which execute treats as a NOP. `illegal` is still reported.

## Test plan
- Reset held 2 cycles, then instr_valid=1, instr=0x24420005 (addiu $2,$2,5) → after 1 edge: d_valid=1, op_class=0000001, rs=2, rt=2, immediate=0x0005, stall=0.
- lw 0x8C430004 held, d_ready=1, waitrequest=1 for 3 cycles → stall=1 and instr_ready=0 for 3 cycles; transfer on the 4th cycle.
- MULT_CYCLES=4: mult (0x00430018) then mflo (0x00001012) back-to-back, d_ready=1 → mflo stall=1 for exactly 4 cycles after the mult transfers.
- lui 0x3C011234 with waitrequest=1 → stall=0, op_class=ALU, transfers immediately.
- Word 0xFC000000: with the macro defined → illegal=1, trap=1 next edge, instr_ready=0 until reset. Without the macro → transfers with op_class=0, trap=0.
- Reset asserted while cnt=20 after a div → cnt=0, d_valid=0; a post-reset mfhi is not stalled.

Source files
------------

// File: rtl/mips_decode_stage.sv
// Registered MIPS decode stage: holds one instruction, decodes fields and one-hot class, and stalls on memory/HI-LO hazards.
// Optional: define DECODE_ILLEGAL_TRAP_EN to make illegal words raise a sticky trap instead of transferring.
module mips_decode_stage #(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        waitrequest,
    input  logic        d_ready,
    output logic        d_valid,
    output logic        stall,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [15:0] immediate,
    output logic [25:0] address,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [6:0]  op_class,
    output logic        illegal,
    output logic        trap
);

    typedef enum logic [6:0] {
        CLS_NONE   = 7'b0000000,
        CLS_ALU    = 7'b0000001,
        CLS_BRANCH = 7'b0000010,
        CLS_JUMP   = 7'b0000100,
        CLS_LOAD   = 7'b0001000,
        CLS_STORE  = 7'b0010000,
        CLS_MULDIV = 7'b0100000,
        CLS_HILO   = 7'b1000000
    } op_class_e;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [31:0]      r_instr;
    op_class_e        r_class;
    logic             r_valid;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;

    op_class_e w_class;
    logic      w_dvalid;
    logic      w_block;
    logic      w_busy;
    logic      w_stall;
    logic      w_xfer;
    logic      w_ready;
    logic      w_accept;
    logic      w_mem;
    logic      w_hilo_dep;

    always_comb begin
        w_class = CLS_NONE;
        case (instr[31:26])
            6'h00: begin
                case (instr[5:0])
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B: w_class = CLS_ALU;
                    6'h08, 6'h09:                                   w_class = CLS_JUMP;
                    6'h10, 6'h11, 6'h12, 6'h13:                     w_class = CLS_HILO;
                    6'h18, 6'h19, 6'h1A, 6'h1B:                     w_class = CLS_MULDIV;
                    default:                                        w_class = CLS_NONE;
                endcase
            end
            // REGIMM: the branch flavour lives in the rt field
            6'h01: begin
                case (instr[20:16])
                    5'h00, 5'h01, 5'h10, 5'h11: w_class = CLS_BRANCH;
                    default:                    w_class = CLS_NONE;
                endcase
            end
            6'h02, 6'h03:                             w_class = CLS_JUMP;
            6'h04, 6'h05:                             w_class = CLS_BRANCH;
            6'h06, 6'h07:                             w_class = (instr[20:16] == 5'd0) ? CLS_BRANCH : CLS_NONE;
            6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: w_class = CLS_ALU;
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: w_class = CLS_LOAD;
            6'h28, 6'h29, 6'h2B:                      w_class = CLS_STORE;
            default:                                  w_class = CLS_NONE;
        endcase
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic r_trap;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_trap <= 1'b0;
        end else if (w_dvalid && r_illegal) begin
            r_trap <= 1'b1;
        end
    end

    // The held word stays registered under a trap; only its visibility is masked.
    assign w_dvalid = r_valid & ~r_trap;
    assign w_block  = r_illegal;
    assign trap     = r_trap;
`else
    assign w_dvalid = r_valid;
    assign w_block  = 1'b0;
    assign trap     = 1'b0;
`endif

    assign w_busy     = (r_cnt != '0);
    assign w_mem      = r_class[3] | r_class[4];
    assign w_hilo_dep = r_class[5] | r_class[6];
    assign w_stall    = ~reset & w_dvalid & ((w_mem & waitrequest) | (w_hilo_dep & w_busy));
    assign w_xfer     = w_dvalid & d_ready & ~w_stall & ~w_block;
    assign w_ready    = ~reset & ~trap & (~w_dvalid | w_xfer);
    assign w_accept   = instr_valid & w_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr   <= '0;
            r_class   <= CLS_NONE;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_instr   <= instr;
                r_class   <= w_class;
                r_illegal <= (w_class == CLS_NONE);
                r_valid   <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
            // funct bit 1 separates div/divu (0x1A/0x1B) from mult/multu (0x18/0x19)
            if (w_xfer && (r_class == CLS_MULDIV)) begin
                r_cnt <= r_instr[1] ? DIV_LOAD : MULT_LOAD;
            end else if (w_busy) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign instr_ready = w_ready;
    assign d_valid     = w_dvalid;
    assign stall       = w_stall;
    assign opcode      = r_instr[31:26];
    assign rs          = r_instr[25:21];
    assign rt          = r_instr[20:16];
    assign rd          = r_instr[15:11];
    assign shamt       = r_instr[10:6];
    assign funct       = r_instr[5:0];
    assign immediate   = r_instr[15:0];
    assign address     = r_instr[25:0];
    assign op_class    = r_class;
    assign illegal     = r_illegal;

endmodule

// File: tb/tb_mips_decode_stage.sv
// Bench for mips_decode_stage: hand-written corner sequences plus a table of instructions checked through a scoreboard.
`timescale 1ns/1ps
module tb_mips_decode_stage;

    localparam logic [6:0] C_NONE = 7'h00, C_ALU = 7'h01, C_BR = 7'h02, C_JMP = 7'h04,
                           C_LD = 7'h08, C_ST = 7'h10, C_MD = 7'h20, C_HL = 7'h40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        waitrequest = 1'b0;
    logic        d_ready = 1'b0;
    logic        instr_ready, d_valid, stall, illegal, trap;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] immediate;
    logic [25:0] address;
    logic [5:0]  opcode, funct;
    logic [6:0]  op_class;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mips_decode_stage #(
        .MULT_CYCLES(4),
        .DIV_CYCLES (32),
        .CNT_W      (6)
    ) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .waitrequest(waitrequest), .d_ready(d_ready),
        .d_valid(d_valid), .stall(stall), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .immediate(immediate), .address(address), .opcode(opcode), .funct(funct),
        .op_class(op_class), .illegal(illegal), .trap(trap)
    );

    typedef struct {
        logic [31:0] w;
        logic [6:0]  cls;
    } vec_t;

    typedef struct {
        logic [31:0] w;
        logic [6:0]  cls;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic logic [63:0] fields_of(input logic [31:0] w);
        logic [63:0] f;
        f = {6'd0, w[25:0], w};
        return f;
    endfunction

    function automatic logic [63:0] fields_now();
        logic [63:0] f;
        f = {6'd0, address, opcode, rs, rt, rd, shamt, funct};
        return f;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[26];
        int   nst;
        int   idx;
        int   cyc;
        logic seen;

        tbl[0]  = '{32'h24420005, C_ALU};  // addiu
        tbl[1]  = '{32'h00430821, C_ALU};  // addu
        tbl[2]  = '{32'h8C430004, C_LD};   // lw
        tbl[3]  = '{32'hAC430004, C_ST};   // sw
        tbl[4]  = '{32'h80430000, C_LD};   // lb
        tbl[5]  = '{32'h98430000, C_LD};   // lwr
        tbl[6]  = '{32'hA0430000, C_ST};   // sb
        tbl[7]  = '{32'h3C011234, C_ALU};  // lui
        tbl[8]  = '{32'h10430003, C_BR};   // beq
        tbl[9]  = '{32'h04410003, C_BR};   // bgez
        tbl[10] = '{32'h04500003, C_BR};   // bltzal
        tbl[11] = '{32'h18400003, C_BR};   // blez
        tbl[12] = '{32'h1C400003, C_BR};   // bgtz
        tbl[13] = '{32'h08000010, C_JMP};  // j
        tbl[14] = '{32'h0C000010, C_JMP};  // jal
        tbl[15] = '{32'h03E00008, C_JMP};  // jr
        tbl[16] = '{32'h00401809, C_JMP};  // jalr
        tbl[17] = '{32'h00021080, C_ALU};  // sll
        tbl[18] = '{32'h00021083, C_ALU};  // sra
        tbl[19] = '{32'h0043082A, C_ALU};  // slt
        tbl[20] = '{32'h38420001, C_ALU};  // xori
        tbl[21] = '{32'h00400011, C_HL};   // mthi
        tbl[22] = '{32'h00001010, C_HL};   // mfhi
        tbl[23] = '{32'h00430019, C_MD};   // multu
        tbl[24] = '{32'h00001012, C_HL};   // mflo (stalls behind multu)
        tbl[25] = '{32'h0043001B, C_MD};   // divu

        // Reset behaviour
        reset = 1'b1; instr_valid = 1'b1; instr = 32'h24420005; d_ready = 1'b0;
        mid();
        check("rst_ready_comb", instr_ready, 1'b0);
        check("rst_stall_comb", stall, 1'b0);
        step(); step();
        check("rst_dvalid", d_valid, 1'b0);
        check("rst_class", op_class, C_NONE);
        check("rst_illegal", illegal, 1'b0);
        check("rst_trap", trap, 1'b0);
        check("rst_fields", {immediate, fields_now()}, '0);
        check("rst_ready", instr_ready, 1'b0);
        reset = 1'b0;

        // First accept: addiu
        mid();
        check("addiu_ready", instr_ready, 1'b1);
        step();
        check("addiu_dvalid", d_valid, 1'b1);
        check("addiu_class", op_class, C_ALU);
        check("addiu_rs_rt", {rs, rt}, {5'd2, 5'd2});
        check("addiu_imm", immediate, 16'h0005);
        check("addiu_stall", stall, 1'b0);

        // Held without d_ready: stable, no accept
        instr = 32'h8C430004;
        mid();
        check("hold_ready", instr_ready, 1'b0);
        step();
        check("hold_fields", fields_now(), fields_of(32'h24420005));
        check("hold_dvalid", d_valid, 1'b1);

        // lw behind waitrequest for 3 cycles
        d_ready = 1'b1;
        mid();
        check("lw_accept_ready", instr_ready, 1'b1);
        step();
        instr_valid = 1'b0; waitrequest = 1'b1;
        check("lw_class", op_class, C_LD);
        for (int k = 0; k < 3; k++) begin
            mid();
            check("lw_stall", stall, 1'b1);
            check("lw_ready_low", instr_ready, 1'b0);
            step();
        end
        waitrequest = 1'b0;
        mid();
        check("lw_release_stall", stall, 1'b0);
        check("lw_release_ready", instr_ready, 1'b1);
        step();
        check("lw_gone", d_valid, 1'b0);

        // lui ignores waitrequest
        instr = 32'h3C011234; instr_valid = 1'b1; waitrequest = 1'b1;
        step();
        instr_valid = 1'b0;
        mid();
        check("lui_stall", stall, 1'b0);
        check("lui_class", op_class, C_ALU);
        check("lui_ready", instr_ready, 1'b1);
        step();
        check("lui_gone", d_valid, 1'b0);
        waitrequest = 1'b0;

        // mult then mflo back-to-back
        instr = 32'h00430018; instr_valid = 1'b1;
        step();
        instr = 32'h00001012;
        mid();
        check("mult_xfer_ready", instr_ready, 1'b1);
        step();
        instr_valid = 1'b0;
        nst = 0; seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            mid();
            if (d_valid && !stall) seen = 1'b1;
            else if (stall) nst++;
            step();
        end
        check("mflo_stall_cycles", nst, 4);
        check("mflo_transferred", seen, 1'b1);
        check("mflo_gone", d_valid, 1'b0);

        // Busy counter keeps counting while execute withholds d_ready
        instr = 32'h00430018; instr_valid = 1'b1;
        step();
        instr = 32'h00001012;
        step();
        instr_valid = 1'b0; d_ready = 1'b0;
        for (int k = 0; k < 6; k++) step();
        check("nordy_stall", stall, 1'b0);
        check("nordy_held", d_valid, 1'b1);
        check("nordy_ready", instr_ready, 1'b0);
        d_ready = 1'b1;
        mid();
        check("nordy_release", instr_ready, 1'b1);
        step();
        check("nordy_gone", d_valid, 1'b0);

        // Reset while a div is still busy
        instr = 32'h0043001A; instr_valid = 1'b1;
        step();
        instr = 32'h00001010;
        step();
        instr_valid = 1'b0;
        for (int k = 0; k < 12; k++) step();
        mid();
        check("div_mfhi_stall", stall, 1'b1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("divrst_dvalid", d_valid, 1'b0);
        check("divrst_stall", stall, 1'b0);
        instr = 32'h00001010; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        mid();
        check("postrst_mfhi_stall", stall, 1'b0);
        check("postrst_mfhi_class", op_class, C_HL);
        check("postrst_mfhi_ready", instr_ready, 1'b1);
        step();

        // Illegal word
        instr = 32'hFC000000; instr_valid = 1'b1;
        step();
        instr = 32'h24420005;
        mid();
        check("ill_flag", illegal, 1'b1);
        check("ill_class", op_class, C_NONE);
`ifdef DECODE_ILLEGAL_TRAP_EN
        check("ill_ready_blocked", instr_ready, 1'b0);
        step();
        check("ill_trap_set", trap, 1'b1);
        check("ill_dvalid_masked", d_valid, 1'b0);
        step(); step();
        check("ill_trap_sticky", trap, 1'b1);
        check("ill_ready_sticky", instr_ready, 1'b0);
`else
        check("ill_dvalid", d_valid, 1'b1);
        check("ill_ready_xfer", instr_ready, 1'b1);
        check("ill_trap_tied", trap, 1'b0);
        step();
        check("ill_next_class", op_class, C_ALU);
        check("ill_next_trap", trap, 1'b0);
`endif
        instr_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("ill_rst_trap", trap, 1'b0);

        // bgtz with rt != 0 is not a supported encoding
        instr = 32'h1C410003; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        mid();
        check("bgtz_rt_illegal", illegal, 1'b1);
        check("bgtz_rt_class", op_class, C_NONE);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;

        // Table run through the scoreboard
        idx = 0; cyc = 0;
        d_ready = 1'b1; waitrequest = 1'b0;
        instr_valid = 1'b1; instr = tbl[0].w;
        while ((idx < 26 || sb.size() > 0) && cyc < 500) begin
            mid();
            if (d_valid && d_ready && !stall) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_xfer", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("tbl_class", op_class, e.cls);
                    check("tbl_illegal", illegal, e.ill);
                    check("tbl_fields", {immediate, fields_now()}, {e.w[15:0], fields_of(e.w)});
                end
            end
            if (instr_valid && instr_ready) begin
                sb.push_back('{tbl[idx].w, tbl[idx].cls, (tbl[idx].cls == C_NONE)});
                idx++;
            end
            step();
            if (idx < 26) instr = tbl[idx].w;
            else instr_valid = 1'b0;
            cyc++;
        end
        check("tbl_all_accepted", idx, 26);
        check("tbl_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
